// File: rtl/cpu_pkg.sv
// Shared CPU definitions: funct3 access-size encodings, datapath width
// and the MEM/WB pipeline register bundle.
package cpu_pkg;

  localparam int XLEN = 32;

  // Load/store access size and sign, as encoded in funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] data;
    logic            exc;
    logic [XLEN-1:0] badaddr;
  } mem_wb_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the MEM stage: merges sub-word store data into
// the current memory word and extracts/extends sub-word load data.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Half and byte starting at the addressed lane (upper bytes zero past lane 3).
  assign half_sel = 16'(rdata >> {lane, 3'b000});
  assign byte_sel = half_sel[7:0];

  // Store merge: overwrite only the addressed bytes, keep the rest of the word.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    wdata = rdata;
    for (int i = 0; i < 4; i++) begin
      if (funct3 == F3_W) begin
        wdata[i*8 +: 8] = rs2[i*8 +: 8];
      end else if (funct3 == F3_H && i == int'(lane)) begin
        wdata[i*8 +: 8] = rs2[7:0];
      end else if (funct3 == F3_H && i == int'(lane) + 1) begin
        wdata[i*8 +: 8] = rs2[15:8];
      end else if (funct3 == F3_B && i == int'(lane)) begin
        wdata[i*8 +: 8] = rs2[7:0];
      end
    end
  end

  // Load extract: sign- or zero-extend the selected lane; anything else is a word.
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data memory, checks access legality,
// gates stores against stall/flush/fault and holds the MEM/WB register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int          DMEM_AW    = 14,
  parameter logic [31:0] RST_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_reg_write,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] dmem_adr,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_exc,
  output logic [XLEN-1:0] wb_badaddr
);

  logic            is_half;
  logic            is_word;
  logic            mis;
  logic            oor;
  logic            fault;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] res;
  mem_wb_t         wb_q;

  // Access legality: natural alignment per size, and address inside the memory.
  assign is_half = (ex_funct3 == F3_H) || (ex_funct3 == F3_HU);
  assign is_word = (ex_funct3 == F3_W);
  assign mis     = (is_half & ex_alu_result[0]) | (is_word & (|ex_alu_result[1:0]));
  assign oor     = |ex_alu_result[XLEN-1:DMEM_AW+2];
  assign fault   = ex_valid & (ex_mem_read | ex_mem_write) & (mis | oor);

  // Memory interface. rst_n is in the enable so a store is cut the instant
  // reset asserts; stall blocks the write so a held store lands exactly once.
  assign dmem_adr = ex_alu_result;
  assign dmem_we  = rst_n & ex_valid & ex_mem_write & ~fault & ~stall & ~flush;

  lsu_align u_lsu_align (
    .lane      (ex_alu_result[1:0]),
    .funct3    (ex_funct3),
    .rs2       (ex_rs2),
    .rdata     (dmem_rdata),
    .wdata     (dmem_wdata),
    .load_data (load_data)
  );

  // A load flagged together with a store behaves as a store (ALU result).
  assign res = (ex_mem_read & ~ex_mem_write) ? load_data : ex_alu_result;

  // MEM/WB register: flush beats stall; badaddr only captures on a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload fields are reset too, so write-back never sees
      // unknown data and wb_badaddr starts at a recognisable tag.
      wb_q.valid     <= 1'b0;
      wb_q.reg_write <= 1'b0;
      wb_q.rd_addr   <= '0;
      wb_q.data      <= '0;
      wb_q.exc       <= 1'b0;
      wb_q.badaddr   <= RST_PC_TAG;
    end else if (flush) begin
      // NOTE: non-blocking assignments for all registered state, so every
      // field samples pre-edge values regardless of statement order.
      wb_q.valid     <= 1'b0;
      wb_q.reg_write <= 1'b0;
      wb_q.exc       <= 1'b0;
    end else if (!stall) begin
      wb_q.valid     <= ex_valid;
      wb_q.reg_write <= ex_valid & ex_reg_write & ~fault;
      wb_q.rd_addr   <= ex_rd_addr;
      wb_q.data      <= res;
      wb_q.exc       <= fault;
      if (fault) begin
        wb_q.badaddr <= ex_alu_result;
      end
    end
  end

  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_rd_addr   = wb_q.rd_addr;
  assign wb_data      = wb_q.data;
  assign wb_exc       = wb_q.exc;
  assign wb_badaddr   = wb_q.badaddr;

endmodule
